pc16_gate: RTL and testbench

//   16-bit Hack program counter. Holds the address of the next instruction
//   and feeds the ROM address bus.
//   - Datapath: a three-level mux16_gate chain (inc / load / reset) selects
//     the next value, which drives a 16-bit register of D flip-flops.
//   - Sits directly downstream of the CPU jump logic (load) and the ALU
//     A-register output (in).
//   - Uses one clock. Reset is synchronous and active-high.

---
 rtl/pc16_gate.sv | 127 ++++++++++++
 tb/tb_pc16_gate.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pc16_gate.sv
// ============================================================================
// Module   : pc16_gate
// Purpose  : 16-bit Hack program counter built from mux, half-adder and DFF gates
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux16_gate (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] out
);
    assign out = sel ? b : a;
endmodule

module half_adder_gate (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module inc16_gate (
    input  logic [15:0] a,
    output logic [15:0] sum,
    output logic        carry_out
);
    logic [16:0] w_carry;

    // Adding 1 is a half-adder ripple with the chain's carry-in tied high.
    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < 16; i++) begin : g_ha
        half_adder_gate u_ha (
            .a     (a[i]),
            .b     (w_carry[i]),
            .sum   (sum[i]),
            .carry (w_carry[i+1])
        );
    end

    assign carry_out = w_carry[16];
endmodule

module dff16_gate (
    input  logic        clk,
    input  logic [15:0] d,
    output logic [15:0] q
);
    always_ff @(posedge clk) begin
        q <= d;
    end
endmodule

module pc16_gate #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        inc,
    output logic [15:0] out,
    output logic        wrap
);
    localparam logic [15:0] C_RESET_VALUE = RESET_VALUE;

    logic [15:0] w_inc_value;
    logic        w_inc_carry;
    logic [15:0] w_after_inc;
    logic [15:0] w_after_load;
    logic [15:0] w_next;
    logic        w_wrap_next;
    logic        r_wrap;

    inc16_gate u_inc (
        .a         (out),
        .sum       (w_inc_value),
        .carry_out (w_inc_carry)
    );

    mux16_gate u_inc_mux (
        .a   (out),
        .b   (w_inc_value),
        .sel (inc),
        .out (w_after_inc)
    );

    mux16_gate u_load_mux (
        .a   (w_after_inc),
        .b   (in),
        .sel (load),
        .out (w_after_load)
    );

    mux16_gate u_reset_mux (
        .a   (w_after_load),
        .b   (C_RESET_VALUE),
        .sel (reset),
        .out (w_next)
    );

    dff16_gate u_reg (
        .clk (clk),
        .d   (w_next),
        .q   (out)
    );

    // Carry out of the incrementer is set only when out is 16'hFFFF.
    assign w_wrap_next = ~reset & ~load & inc & w_inc_carry;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign wrap = r_wrap;
endmodule

`default_nettype wire

// File: tb/tb_pc16_gate.sv
// ============================================================================
// Module   : tb_pc16_gate
// Purpose  : Directed-vector scoreboard bench for pc16_gate
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc16_gate;
    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic [15:0] out;
    logic        wrap;

    logic [16:0] exp_q[$];
    int          n_checks;
    int          n_fails;

    pc16_gate #(.RESET_VALUE(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .load  (load),
        .inc   (inc),
        .out   (out),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per posedge once stimulus starts.
    initial begin
        logic [16:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out !== e[16:1]) begin
                    n_fails++;
                    $display("FAIL out: got %h expected %h at %0t", out, e[16:1], $time);
                end
                n_checks++;
                if (wrap !== e[0]) begin
                    n_fails++;
                    $display("FAIL wrap: got %b expected %b at %0t", wrap, e[0], $time);
                end
            end
        end
    end

    task automatic step(input logic r, input logic l, input logic i,
                        input logic [15:0] d, input logic [15:0] eo, input logic ew);
        @(negedge clk);
        reset = r;
        load  = l;
        inc   = i;
        in    = d;
        exp_q.push_back({eo, ew});
    endtask

    initial begin
        int budget;
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b0;
        load  = 1'b0;
        inc   = 1'b0;
        in    = 16'h0000;

        // Reset beats load and inc
        step(1, 1, 1, 16'h1234, 16'h0000, 0);
        // Count then hold
        step(0, 0, 1, 16'h0000, 16'h0001, 0);
        step(0, 0, 1, 16'h0000, 16'h0002, 0);
        step(0, 0, 1, 16'h0000, 16'h0003, 0);
        step(0, 0, 0, 16'h0000, 16'h0003, 0);
        step(0, 0, 0, 16'h0000, 16'h0003, 0);
        // Load beats inc
        step(0, 1, 1, 16'hABCD, 16'hABCD, 0);
        step(0, 0, 1, 16'hABCD, 16'hABCE, 0);
        // Wrap
        step(0, 1, 0, 16'hFFFE, 16'hFFFE, 0);
        step(0, 0, 1, 16'h0000, 16'hFFFF, 0);
        step(0, 0, 1, 16'h0000, 16'h0000, 1);
        step(0, 0, 0, 16'h0000, 16'h0000, 0);
        // Wrap pulse clears after the following inc
        step(0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
        step(0, 0, 1, 16'h1111, 16'h0000, 1);
        step(0, 0, 1, 16'h2222, 16'h0001, 0);
        // Load of FFFF with inc set must not raise wrap
        step(0, 1, 1, 16'hFFFF, 16'hFFFF, 0);
        step(0, 1, 1, 16'h0000, 16'h0000, 0);
        // Sampling: in toggles between edges with load low
        step(0, 0, 0, 16'h0000, 16'h0000, 0);
        #2 in = 16'hFFFF;
        step(0, 0, 0, 16'hFFFF, 16'h0000, 0);
        #2 in = 16'h0000;
        step(0, 1, 0, 16'h5555, 16'h5555, 0);
        step(0, 0, 0, 16'hAAAA, 16'h5555, 0);
        // Mid-run reset
        step(0, 1, 0, 16'h000F, 16'h000F, 0);
        step(0, 0, 1, 16'h0000, 16'h0010, 0);
        step(1, 0, 1, 16'h0000, 16'h0000, 0);
        step(0, 0, 1, 16'h0000, 16'h0001, 0);

        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        inc   = 1'b0;

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

`default_nettype wire
